// File: rtl/rtttl_tone_gen_if.sv
// Sequencer-to-tone-generator link: note selection in, speaker drive and activity flag out.
interface rtttl_tone_gen_if;
   logic       en;
   logic [3:0] octave;
   logic [3:0] note;
   logic       tone_out;
   logic       active;

   modport master (output en, octave, note, input tone_out, active);
   modport slave (input en, octave, note, output tone_out, active);
endinterface

// File: rtl/rtttl_tone_gen.sv
// Converts (octave, note) into a 50%-duty square wave; half-period table calibrated for 1 MHz.
// Define TONE_GAP_EN to insert a silent GAP_CYCLES articulation gap before each new note.
module rtttl_tone_gen #(
   parameter int unsigned MAX_OCTAVE = 8
`ifdef TONE_GAP_EN
   ,
   parameter int unsigned GAP_CYCLES = 1000
`endif
) (
   input logic             clk,
   input logic             rstn,
   rtttl_tone_gen_if.slave bus
);

   typedef enum logic [1:0] {StSilent, StLoad, StRun, StGap} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cur_oct_q, cur_note_q;
   logic [15:0] half_q, half_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] base, scaled;
   logic        tone_q, tone_d;
   logic        change, cur_valid;

`ifdef TONE_GAP_EN
   localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);
   logic [15:0] gap_cnt_q, gap_cnt_d;
`endif

   function automatic logic pair_valid(logic [3:0] oct, logic [3:0] nt);
      return (nt >= 4'd1) && (nt <= 4'd12) && (32'(oct) <= MAX_OCTAVE);
   endfunction

   assign change    = {bus.octave, bus.note} != {cur_oct_q, cur_note_q};
   assign cur_valid = pair_valid(cur_oct_q, cur_note_q);

   // Octave-4 half-periods in clk cycles.
   always_comb begin
      case (cur_note_q)
         4'd1:    base = 16'd1911;
         4'd2:    base = 16'd1804;
         4'd3:    base = 16'd1703;
         4'd4:    base = 16'd1607;
         4'd5:    base = 16'd1517;
         4'd6:    base = 16'd1432;
         4'd7:    base = 16'd1351;
         4'd8:    base = 16'd1276;
         4'd9:    base = 16'd1204;
         4'd10:   base = 16'd1136;
         4'd11:   base = 16'd1073;
         4'd12:   base = 16'd1012;
         default: base = 16'd0;
      endcase
   end

   always_comb begin
      if (cur_oct_q < 4'd4) scaled = base << (4'd4 - cur_oct_q);
      else                  scaled = base >> (cur_oct_q - 4'd4);
   end

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      cnt_d   = cnt_q;
      tone_d  = tone_q;
`ifdef TONE_GAP_EN
      gap_cnt_d = gap_cnt_q;
`endif
      if (!bus.en) begin
         state_d = StSilent;
         cnt_d   = '0;
         tone_d  = 1'b0;
      end else if (change) begin
         // Every change restarts the phase low; rests still pass through LOAD.
         cnt_d  = '0;
         tone_d = 1'b0;
`ifdef TONE_GAP_EN
         if (pair_valid(bus.octave, bus.note)) begin
            state_d   = StGap;
            gap_cnt_d = '0;
         end else begin
            state_d = StLoad;
         end
`else
         state_d = StLoad;
`endif
      end else begin
         unique case (state_q)
            StSilent: begin
               cnt_d  = '0;
               tone_d = 1'b0;
               if (cur_valid) state_d = StLoad;
            end
            StLoad: begin
               half_d  = scaled;
               cnt_d   = '0;
               tone_d  = 1'b0;
               state_d = cur_valid ? StRun : StSilent;
            end
            StRun: begin
               if (cnt_q == half_q - 16'd1) begin
                  cnt_d  = '0;
                  tone_d = ~tone_q;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
`ifdef TONE_GAP_EN
            StGap: begin
               tone_d = 1'b0;
               if (gap_cnt_q == GapLast) state_d = StLoad;
               else                      gap_cnt_d = gap_cnt_q + 16'd1;
            end
`endif
            default: begin
               state_d = StSilent;
               cnt_d   = '0;
               tone_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StSilent;
         cur_oct_q  <= '0;
         cur_note_q <= '0;
         half_q     <= '0;
         cnt_q      <= '0;
         tone_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_oct_q  <= bus.octave;
         cur_note_q <= bus.note;
         half_q     <= half_d;
         cnt_q      <= cnt_d;
         tone_q     <= tone_d;
      end
   end

`ifdef TONE_GAP_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) gap_cnt_q <= '0;
      else       gap_cnt_q <= gap_cnt_d;
   end
`endif

   assign bus.tone_out = tone_q;
   assign bus.active   = (state_q == StRun);

endmodule
